// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//  - Access size codes carried on *_byte_en signals.
//  - Arbiter FSM state and transaction owner enums.
//  - Bus widths used by the interface and the arbiter.
package mem_port_arbiter_pkg;

    localparam logic [1:0] BYTE        = 2'd0;
    localparam logic [1:0] HALF_WORD   = 2'd1;
    localparam logic [1:0] WORD        = 2'd2;
    localparam logic [1:0] DOUBLE_WORD = 2'd3;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned INSN_W = 32;

    typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_ERROR} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle around the memory port arbiter: IF request port, DM request port,
// memory port and the timeout flag.
//  modport slave  : the arbiter's view (requests/memory responses in, grants/mem_* out).
//  modport master : the surrounding fetch/memory-stage/memory view (mirror of slave).
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    // Instruction fetch port (read-only)
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [INSN_W-1:0] if_rdata_o;

    // Memory stage port (read/write)
    logic              dm_req_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [1:0]        dm_byte_en_i;
    logic              dm_wr_i;
    logic [DATA_W-1:0] dm_wr_data_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DATA_W-1:0] dm_rdata_o;

    // Memory port
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [1:0]        mem_byte_en_o;
    logic              mem_wr_o;
    logic [DATA_W-1:0] mem_wr_data_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rd_data_i;

    logic              err_timeout_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_addr_i, dm_byte_en_i, dm_wr_i, dm_wr_data_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rd_data_i,
        output err_timeout_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_addr_i, dm_byte_en_i, dm_wr_i, dm_wr_data_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        output mem_gnt_i, mem_rvalid_i, mem_rd_data_i,
        input  err_timeout_o
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the memory stage (DM).
// One outstanding transaction; DM has priority unless IF has been starved for
// STARVE_LIMIT consecutive DM grants; a missing response raises a sticky timeout.
// Ports:
//  clk   - clock, rising edge
//  reset - synchronous reset, active-low
//  bus   - mem_port_arbiter_if.slave: IF/DM request ports, memory port, err_timeout_o
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned RESP_TIMEOUT = 256,
    parameter int unsigned CNT_W        = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t        r_state, w_state_d;
    arb_owner_t        r_owner, w_owner_d;
    arb_owner_t        r_lock_own, w_lock_own_d;
    logic              r_locked, w_locked_d;
    logic [SW-1:0]     r_starve_cnt, w_starve_d;
    logic [CNT_W-1:0]  r_to_cnt, w_to_d;
    logic              r_err, w_err_d;

    arb_owner_t        w_sel;
    logic              w_dm_wins;
    logic              w_if_gnt, w_dm_gnt, w_if_rvalid, w_dm_rvalid;
    logic [INSN_W-1:0] w_if_rdata;
    logic [DATA_W-1:0] w_dm_rdata;
    logic              w_mem_req, w_mem_wr, w_err_out;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [1:0]        w_mem_byte_en;
    logic [DATA_W-1:0] w_mem_wr_data;

    // A stalled winner stays locked so the payload on mem_* cannot change under it.
    assign w_dm_wins = bus.dm_req_i &&
                       !(bus.if_req_i && (r_starve_cnt == SW'(STARVE_LIMIT)));
    assign w_sel     = r_locked ? r_lock_own : (w_dm_wins ? OWN_DM : OWN_IF);

    always_comb begin
        w_state_d     = r_state;
        w_owner_d     = r_owner;
        w_lock_own_d  = r_lock_own;
        w_locked_d    = r_locked;
        w_to_d        = r_to_cnt;
        w_err_d       = r_err;
        w_if_gnt      = 1'b0;
        w_dm_gnt      = 1'b0;
        w_if_rvalid   = 1'b0;
        w_dm_rvalid   = 1'b0;
        w_if_rdata    = '0;
        w_dm_rdata    = '0;
        w_mem_req     = 1'b0;
        w_mem_addr    = '0;
        w_mem_byte_en = 2'b00;
        w_mem_wr      = 1'b0;
        w_mem_wr_data = '0;
        w_err_out     = r_err;

        unique case (r_state)
            ARB_IDLE: begin
                w_mem_req = bus.if_req_i | bus.dm_req_i;
                if (w_mem_req) begin
                    if (w_sel == OWN_DM) begin
                        w_mem_addr    = bus.dm_addr_i;
                        w_mem_byte_en = bus.dm_byte_en_i;
                        w_mem_wr      = bus.dm_wr_i;
                        w_mem_wr_data = bus.dm_wr_data_i;
                    end else begin
                        w_mem_addr    = bus.if_addr_i;
                        w_mem_byte_en = WORD;
                    end
                    if (bus.mem_gnt_i) begin
                        w_dm_gnt   = (w_sel == OWN_DM);
                        w_if_gnt   = (w_sel == OWN_IF);
                        w_owner_d  = w_sel;
                        w_locked_d = 1'b0;
                        w_to_d     = '0;
                        w_state_d  = ARB_WAIT;
                    end else begin
                        w_locked_d   = 1'b1;
                        w_lock_own_d = w_sel;
                    end
                end
            end
            ARB_WAIT: begin
                w_to_d = r_to_cnt + CNT_W'(1);
                if (bus.mem_rvalid_i) begin
                    w_if_rvalid = (r_owner == OWN_IF);
                    w_dm_rvalid = (r_owner == OWN_DM);
                    w_if_rdata  = (r_owner == OWN_IF) ? bus.mem_rd_data_i[INSN_W-1:0] : '0;
                    w_dm_rdata  = (r_owner == OWN_DM) ? bus.mem_rd_data_i : '0;
                    w_state_d   = ARB_IDLE;
                end else if (r_to_cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                    // Release the owner with zero data so the pipeline is not left hanging.
                    w_if_rvalid = (r_owner == OWN_IF);
                    w_dm_rvalid = (r_owner == OWN_DM);
                    w_err_d     = 1'b1;
                    w_err_out   = 1'b1;
                    w_state_d   = ARB_ERROR;
                end
            end
            ARB_ERROR: begin
            end
            default: w_state_d = ARB_IDLE;
        endcase

        // Outputs are held quiet while reset is asserted.
        if (!reset) begin
            w_if_gnt      = 1'b0;
            w_dm_gnt      = 1'b0;
            w_if_rvalid   = 1'b0;
            w_dm_rvalid   = 1'b0;
            w_if_rdata    = '0;
            w_dm_rdata    = '0;
            w_mem_req     = 1'b0;
            w_mem_addr    = '0;
            w_mem_byte_en = 2'b00;
            w_mem_wr      = 1'b0;
            w_mem_wr_data = '0;
            w_err_out     = 1'b0;
        end
    end

    // Starvation counter: counts DM wins while IF waits, saturating at the limit.
    always_comb begin
        w_starve_d = r_starve_cnt;
        if (!bus.if_req_i || w_if_gnt) begin
            w_starve_d = '0;
        end else if (w_dm_gnt && (r_starve_cnt < SW'(STARVE_LIMIT))) begin
            w_starve_d = r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWN_DM;
            r_lock_own   <= OWN_DM;
            r_locked     <= 1'b0;
            r_starve_cnt <= '0;
            r_to_cnt     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_owner      <= w_owner_d;
            r_lock_own   <= w_lock_own_d;
            r_locked     <= w_locked_d;
            r_starve_cnt <= w_starve_d;
            r_to_cnt     <= w_to_d;
            r_err        <= w_err_d;
        end
    end

    assign bus.if_gnt_o      = w_if_gnt;
    assign bus.if_rvalid_o   = w_if_rvalid;
    assign bus.if_rdata_o    = w_if_rdata;
    assign bus.dm_gnt_o      = w_dm_gnt;
    assign bus.dm_rvalid_o   = w_dm_rvalid;
    assign bus.dm_rdata_o    = w_dm_rdata;
    assign bus.mem_req_o     = w_mem_req;
    assign bus.mem_addr_o    = w_mem_addr;
    assign bus.mem_byte_en_o = w_mem_byte_en;
    assign bus.mem_wr_o      = w_mem_wr;
    assign bus.mem_wr_data_o = w_mem_wr_data;
    assign bus.err_timeout_o = w_err_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters:
// STARVE_LIMIT=4, RESP_TIMEOUT=256). Inputs change 1 time unit after the rising
// edge; outputs are sampled 2 time units after the rising edge.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_i      = 1'b0;
        bus.if_addr_i     = '0;
        bus.dm_req_i      = 1'b0;
        bus.dm_addr_i     = '0;
        bus.dm_byte_en_i  = 2'b00;
        bus.dm_wr_i       = 1'b0;
        bus.dm_wr_data_i  = '0;
        bus.mem_gnt_i     = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rd_data_i = '0;
    endtask

    logic [1:0] exp_gnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        idle_inputs();

        // Reset state
        cyc();
        cyc();
        settle();
        chk("rst_mem_req", bus.mem_req_o, 1'b0);
        chk("rst_gnts", {bus.if_gnt_o, bus.dm_gnt_o}, 2'b00);
        chk("rst_rvalids", {bus.if_rvalid_o, bus.dm_rvalid_o}, 2'b00);
        chk("rst_err", bus.err_timeout_o, 1'b0);
        cyc();
        reset = 1'b1;

        // 1: DM read, memory ready, response two cycles later
        cyc();
        bus.dm_req_i     = 1'b1;
        bus.dm_addr_i    = 64'h1000;
        bus.dm_byte_en_i = DOUBLE_WORD;
        bus.mem_gnt_i    = 1'b1;
        settle();
        chk("t1_dm_gnt", bus.dm_gnt_o, 1'b1);
        chk("t1_if_gnt", bus.if_gnt_o, 1'b0);
        chk("t1_mem_req", bus.mem_req_o, 1'b1);
        chk("t1_mem_addr", bus.mem_addr_o, 64'h1000);
        chk("t1_mem_be", bus.mem_byte_en_o, DOUBLE_WORD);
        cyc();
        idle_inputs();
        settle();
        chk("t1_wait_req", bus.mem_req_o, 1'b0);
        cyc();
        cyc();
        bus.mem_rvalid_i  = 1'b1;
        bus.mem_rd_data_i = 64'hDEAD_BEEF_0123_4567;
        bus.if_req_i      = 1'b1;
        bus.if_addr_i     = 64'h40;
        bus.mem_gnt_i     = 1'b1;
        settle();
        chk("t1_dm_rvalid", bus.dm_rvalid_o, 1'b1);
        chk("t1_dm_rdata", bus.dm_rdata_o, 64'hDEAD_BEEF_0123_4567);
        chk("t1_if_rvalid", bus.if_rvalid_o, 1'b0);
        chk("t1_no_regrant", bus.if_gnt_o, 1'b0);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        settle();
        chk("t1_rvalid_pulse", bus.dm_rvalid_o, 1'b0);
        chk("t1_if_gnt_next", bus.if_gnt_o, 1'b1);
        cyc();
        bus.if_req_i     = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        settle();
        chk("t1_if_rvalid2", bus.if_rvalid_o, 1'b1);
        chk("t1_if_rdata", bus.if_rdata_o, 64'h0123_4567);
        chk("t1_dm_rvalid2", bus.dm_rvalid_o, 1'b0);
        cyc();
        idle_inputs();

        // 2: both requesters held, memory always ready -> DM x4, IF, DM
        for (int k = 0; k < 6; k++) begin
            cyc();
            bus.if_req_i     = 1'b1;
            bus.if_addr_i    = 64'h80;
            bus.dm_req_i     = 1'b1;
            bus.dm_addr_i    = 64'h2000;
            bus.dm_byte_en_i = WORD;
            bus.mem_gnt_i    = 1'b1;
            bus.mem_rvalid_i = 1'b0;
            settle();
            exp_gnt = (k == 4) ? 2'b10 : 2'b01;
            chk($sformatf("t2_gnt%0d", k), {bus.if_gnt_o, bus.dm_gnt_o}, exp_gnt);
            cyc();
            bus.mem_rvalid_i = 1'b1;
        end
        cyc();
        idle_inputs();

        // 3: IF request stalled by memory for 3 cycles; DM arriving mid-stall must not steal it
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = 64'h8000_0040;
            bus.dm_req_i  = (k > 0);
            bus.dm_addr_i = 64'h3000;
            bus.dm_wr_i   = 1'b1;
            bus.mem_gnt_i = 1'b0;
            settle();
            chk($sformatf("t3_req%0d", k), bus.mem_req_o, 1'b1);
            chk($sformatf("t3_addr%0d", k), bus.mem_addr_o, 64'h8000_0040);
            chk($sformatf("t3_be%0d", k), bus.mem_byte_en_o, WORD);
            chk($sformatf("t3_wr%0d", k), bus.mem_wr_o, 1'b0);
            chk($sformatf("t3_gnts%0d", k), {bus.if_gnt_o, bus.dm_gnt_o}, 2'b00);
        end
        cyc();
        bus.mem_gnt_i = 1'b1;
        settle();
        chk("t3_if_gnt", {bus.if_gnt_o, bus.dm_gnt_o}, 2'b10);
        cyc();
        idle_inputs();
        bus.mem_rvalid_i  = 1'b1;
        bus.mem_rd_data_i = 64'h1111_2222_3333_4444;
        settle();
        chk("t3_if_rdata", bus.if_rdata_o, 64'h3333_4444);
        cyc();
        idle_inputs();

        // 4: DM write with no response -> timeout
        cyc();
        bus.dm_req_i     = 1'b1;
        bus.dm_addr_i    = 64'h4000;
        bus.dm_byte_en_i = WORD;
        bus.dm_wr_i      = 1'b1;
        bus.dm_wr_data_i = 64'hA5A5_0000_5A5A;
        bus.mem_gnt_i    = 1'b1;
        settle();
        chk("t4_dm_gnt", bus.dm_gnt_o, 1'b1);
        chk("t4_mem_wr", bus.mem_wr_o, 1'b1);
        chk("t4_mem_wdata", bus.mem_wr_data_o, 64'hA5A5_0000_5A5A);
        cyc();
        idle_inputs();
        repeat (254) cyc();
        settle();
        chk("t4_pre_rvalid", bus.dm_rvalid_o, 1'b0);
        chk("t4_pre_err", bus.err_timeout_o, 1'b0);
        cyc();
        settle();
        chk("t4_to_rvalid", bus.dm_rvalid_o, 1'b1);
        chk("t4_to_rdata", bus.dm_rdata_o, 64'h0);
        chk("t4_to_err", bus.err_timeout_o, 1'b1);
        chk("t4_to_if_rvalid", bus.if_rvalid_o, 1'b0);
        cyc();
        bus.if_req_i      = 1'b1;
        bus.if_addr_i     = 64'h90;
        bus.mem_gnt_i     = 1'b1;
        bus.mem_rvalid_i  = 1'b1;
        bus.mem_rd_data_i = 64'h77;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t4_err_gnt%0d", k), {bus.if_gnt_o, bus.mem_req_o}, 2'b00);
            chk($sformatf("t4_err_rv%0d", k), {bus.if_rvalid_o, bus.dm_rvalid_o}, 2'b00);
            chk($sformatf("t4_err_sticky%0d", k), bus.err_timeout_o, 1'b1);
            cyc();
        end
        idle_inputs();

        // 5: reset from ERROR, then reset during WAIT with a stale response
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        settle();
        chk("t5_err_cleared", bus.err_timeout_o, 1'b0);
        cyc();
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 64'h5000;
        bus.mem_gnt_i = 1'b1;
        settle();
        chk("t5_dm_gnt", bus.dm_gnt_o, 1'b1);
        cyc();
        idle_inputs();
        reset = 1'b0;
        cyc();
        reset             = 1'b1;
        bus.mem_rvalid_i  = 1'b1;
        bus.mem_rd_data_i = 64'h55;
        settle();
        chk("t5_stale_rvalid", {bus.if_rvalid_o, bus.dm_rvalid_o}, 2'b00);
        chk("t5_stale_rdata", bus.dm_rdata_o, 64'h0);
        chk("t5_stale_req", bus.mem_req_o, 1'b0);
        chk("t5_stale_err", bus.err_timeout_o, 1'b0);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        bus.if_req_i     = 1'b1;
        bus.if_addr_i    = 64'h3000;
        bus.mem_gnt_i    = 1'b1;
        settle();
        chk("t5_if_gnt", bus.if_gnt_o, 1'b1);
        chk("t5_if_addr", bus.mem_addr_o, 64'h3000);
        cyc();
        idle_inputs();
        bus.mem_rvalid_i  = 1'b1;
        bus.mem_rd_data_i = 64'hFFFF_FFFF_8765_4321;
        settle();
        chk("t5_if_rvalid", bus.if_rvalid_o, 1'b1);
        chk("t5_if_rdata", bus.if_rdata_o, 64'h8765_4321);
        cyc();
        idle_inputs();

        // 6: response exactly in the threshold cycle wins over the timeout
        cyc();
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 64'h6000;
        bus.mem_gnt_i = 1'b1;
        settle();
        chk("t6_dm_gnt", bus.dm_gnt_o, 1'b1);
        cyc();
        idle_inputs();
        repeat (254) cyc();
        cyc();
        bus.mem_rvalid_i  = 1'b1;
        bus.mem_rd_data_i = 64'hCAFE_F00D;
        settle();
        chk("t6_rvalid", bus.dm_rvalid_o, 1'b1);
        chk("t6_rdata", bus.dm_rdata_o, 64'hCAFE_F00D);
        chk("t6_err", bus.err_timeout_o, 1'b0);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        bus.dm_req_i     = 1'b1;
        bus.dm_addr_i    = 64'h6008;
        bus.mem_gnt_i    = 1'b1;
        settle();
        chk("t6_idle_gnt", bus.dm_gnt_o, 1'b1);
        chk("t6_err_after", bus.err_timeout_o, 1'b0);
        cyc();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        cyc();
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
